// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per clock, then a sign fix-up cycle.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam logic [CNT_WIDTH-1:0] CntInit = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q;
  logic                    is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic                    busy_q, done_q;
  logic [DATA_WIDTH-1:0]   hi_q, lo_q;

  // Operand conditioning at latch time
  logic                    signed_op, rs_neg, rt_neg;
  logic [DATA_WIDTH-1:0]   rs_mag, rt_mag;

  // Iteration step
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_part;
  logic                    div_ge;
  logic [DATA_WIDTH-1:0]   div_diff;
  logic [DATA_WIDTH-1:0]   step_hi, step_lo;

  // Fix-up results
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_data[DATA_WIDTH-1];
    rt_neg    = signed_op & rt_data[DATA_WIDTH-1];
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;
  end

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_part = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
    div_ge   = div_part >= {1'b0, opnd_q};
    // A successful trial always leaves a remainder below the divisor, so it fits in DATA_WIDTH
    div_diff = div_part[DATA_WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_part[DATA_WIDTH-1:0];
      step_lo = {acc_lo_q[DATA_WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quot_fix = div_zero_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
    // Divide-by-zero leaves |dividend| here, so restoring its sign yields the original dividend
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            if (!op[2]) begin
              state_q    <= StRun;
              cnt_q      <= CntInit;
              busy_q     <= 1'b1;
              acc_hi_q   <= '0;
              acc_lo_q   <= op[1] ? rs_mag : rt_mag;
              opnd_q     <= op[1] ? rt_mag : rs_mag;
              is_div_q   <= op[1];
              neg_res_q  <= rs_neg ^ rt_neg;
              neg_rem_q  <= rs_neg;
              div_zero_q <= op[1] && (rt_data == '0);
            end else if (!op[1]) begin
              if (op[0]) lo_q <= rs_data;
              else       hi_q <= rs_data;
            end
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - CntLast;
            if (cnt_q == CntLast) state_q <= StFixup;
          end
        end
        StFixup: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          if (!flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
              lo_q <= prod_fix[DATA_WIDTH-1:0];
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers; gives the pipelined core the MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO path it lacks today.
- Sits beside the ALU in EX. Takes forwarded operands from the EX-stage operand muxes.
- Exposes HI/LO to the MFHI/MFLO writeback mux.
- Drives a busy signal into the hazard detection unit. Width is parametrised.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; must be >= 4.
- CNT_WIDTH, $clog2(DATA_WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin op; sampled on clk edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- rs_data  input  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO source
- rt_data  input  DATA_WIDTH  multiplier / divisor
- flush  input  1  abort in-flight op (branch/jump squash)
- busy  output  1  op in progress; hazard unit stalls MFHI/MFLO/new mult-div while high
- done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV op
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, named reset.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation: outputs clear immediately, without waiting for a clock edge; the op is lost.
- States:
  - IDLE: start=1 with MULT/MULTU/DIV/DIVU -> latch operands, go to RUN, counter=DATA_WIDTH, busy=1.
  - IDLE: MTHI/MTLO -> write hi/lo from rs_data at that edge; stay IDLE; no busy, no done.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; counter decrements. At counter==1 the step is taken and the state goes to FIXUP.
  - FIXUP: apply sign correction, write hi/lo, return to IDLE.
- Timing: done=1 and busy=0 in the cycle after the FIXUP edge.
- Latency: busy is high for exactly DATA_WIDTH+1 cycles after the accepting edge. New hi/lo are visible DATA_WIDTH+1 edges after the start edge.
- Signed ops:
  - Operands are converted to magnitudes at latch time.
  - Multiply: product negated if signs differ.
  - Divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Results truncate to DATA_WIDTH.
  - MIN / -1 gives lo=MIN, hi=0.
- Multiply: {hi,lo} = full 2*DATA_WIDTH product.
- Divide: lo=quotient, hi=remainder.
- Divide by zero: same latency; hi=original dividend (rs_data as latched), lo=all ones. Applies to signed and unsigned divide.
- start while busy: ignored, no effect. The hazard unit guarantees this never occurs legitimately.
- start in the same cycle as done: accepted normally.
- flush while busy: next edge returns to IDLE, busy=0. hi/lo keep their pre-op values; no done pulse.
- flush with start in the same cycle: flush wins; start is ignored, including MTHI/MTLO.
- flush in IDLE with no start: no effect.
- MTHI/MTLO are not pipelined with a running op: they are ignored while busy.

Test Plan (DATA_WIDTH=32):
- MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle; busy high exactly 33 cycles.
- MULT, rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, rs=7, rt=0 -> hi=7, lo=0xFFFFFFFF after the normal 33-edge latency.
- DIV, rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Abort and reset cases:
  - MTHI 0x1234, then MULT 5*6, flush on the 10th busy cycle -> busy=0 next cycle; hi=0x1234 kept; no done.
  - A second start during busy changes nothing.
  - reset pulsed mid-DIV between clock edges -> hi=lo=0 and busy=done=0 immediately.
